// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial W-bit subtractor sequencer (diff = a - b).
// One bit per cycle through a full subtractor made of two half-subtractor
// stages, driven by a start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_ABS_EN. When it is defined, a negative
// result is re-negated serially in a NEG pass, and the neg port reports it.
module serial_sub_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow
`ifdef SERIAL_SUB_ABS_EN
   ,
   output logic         neg
`endif
);

   localparam int CW = $clog2(W + 1);

`ifdef SERIAL_SUB_ABS_EN
   typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;
`endif

   state_t         state;
   logic [W-1:0]   sa, sb, res;
   logic           bin;
   logic [CW-1:0]  cnt;

   // bit-cell signals
   logic           x, y, h1_d, h1_b, d, bout;
   logic [W-1:0]   res_nxt;
   logic           last;

   // Full subtractor built from two half-subtractors, plus the LSB-first
   // result fill that includes the bit being produced this cycle.
   always_comb begin
      x       = sa[0];
      y       = sb[0];
      h1_d    = x ^ y;
      h1_b    = ~x & y;
      d       = h1_d ^ bin;
      bout    = h1_b | (~h1_d & bin);
      res_nxt = res >> 1;
      res_nxt[W-1] = d;
      last    = (cnt == CW'(W - 1));
   end

   // Sequencer: loads operands, runs W serial steps per pass, registers
   // the result on DONE entry and pulses done for a single cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         bin    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_ABS_EN
         neg    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  bin   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_SUB;
               end
            end
            S_SUB: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= res_nxt;
               bin <= bout;
               cnt <= cnt + CW'(1);
               if (last) begin
`ifdef SERIAL_SUB_ABS_EN
                  if (bout) begin
                     // negative: second pass computes 0 - result
                     sa    <= '0;
                     sb    <= res_nxt;
                     bin   <= 1'b0;
                     cnt   <= '0;
                     state <= S_NEG;
                  end else begin
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     diff   <= res_nxt;
                     borrow <= 1'b0;
                     neg    <= 1'b0;
                     state  <= S_DONE;
                  end
`else
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  diff   <= res_nxt;
                  borrow <= bout;
                  state  <= S_DONE;
`endif
               end
            end
`ifdef SERIAL_SUB_ABS_EN
            S_NEG: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= res_nxt;
               bin <= bout;
               cnt <= cnt + CW'(1);
               if (last) begin
                  // original subtraction underflowed, so borrow stays set
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  diff   <= res_nxt;
                  borrow <= 1'b1;
                  neg    <= 1'b1;
                  state  <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: W=8 and W=1 instances, table vectors, hand
// sequences for ignored start and mid-pass reset, and random operands
// checked against plain-arithmetic expectations.
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start1;
   logic [7:0] a8, b8, diff8;
   logic [0:0] a1, b1, diff1;
   logic       busy8, done8, borrow8, busy1, done1, borrow1;
`ifdef SERIAL_SUB_ABS_EN
   logic       neg8, neg1;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] last_diff;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.W(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_ABS_EN
      , .neg(neg8)
`endif
   );

   serial_sub_ctrl #(.W(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_ABS_EN
      , .neg(neg1)
`endif
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       br;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One W=8 transaction; expectation given as the raw modular difference.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ed_raw, input logic eb);
      logic [7:0] ed;
      logic       en;
      int         lat, cyc;
      ed  = ed_raw;
      en  = 1'b0;
      lat = 9;
`ifdef SERIAL_SUB_ABS_EN
      if (eb) begin
         ed  = 8'(0 - int'(ed_raw));
         en  = 1'b1;
         lat = 17;
      end
`endif
      start8 = 1'b1; a8 = ia; b8 = ib;
      tick();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      cyc = 1;
      while (done8 !== 1'b1 && cyc <= lat + 2) begin
         check("busy8", 32'(busy8), 32'd1);
         check("hold8", 32'(diff8), 32'(last_diff));
         tick();
         cyc++;
      end
      check("lat8", cyc, lat);
      check("diff8", 32'(diff8), 32'(ed));
      check("borrow8", 32'(borrow8), 32'(eb));
      check("busy_at_done8", 32'(busy8), 32'd0);
`ifdef SERIAL_SUB_ABS_EN
      check("neg8", 32'(neg8), 32'(en));
`else
      en = en;
`endif
      last_diff = ed;
      tick();
      check("done_pulse8", 32'(done8), 32'd0);
      check("diff_held8", 32'(diff8), 32'(ed));
   endtask

   task automatic run1(input logic ia, input logic ib);
      logic ed, eb;
      int   lat, cyc;
      ed  = ia ^ ib;         // |a-b| and a-b mod 2 coincide for one bit
      eb  = (ia < ib);
      lat = 2;
`ifdef SERIAL_SUB_ABS_EN
      if (eb) lat = 3;
`endif
      start1 = 1'b1; a1 = ia; b1 = ib;
      tick();
      start1 = 1'b0;
      cyc = 1;
      while (done1 !== 1'b1 && cyc <= lat + 2) begin
         check("busy1", 32'(busy1), 32'd1);
         tick();
         cyc++;
      end
      check("lat1", cyc, lat);
      check("diff1", 32'(diff1), 32'(ed));
      check("borrow1", 32'(borrow1), 32'(eb));
      tick();
      check("done_pulse1", 32'(done1), 32'd0);
   endtask

   initial begin
      int ndone, done_at;
      logic [7:0] d_at;
      logic [7:0] ra, rb;

      tbl[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
      tbl[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
      tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tbl[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      tbl[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};

      rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;
      last_diff = 8'h00;
      tick(); tick();
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_borrow", 32'(borrow8), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      rst = 1'b0;
      tick();

      // table vectors (T1..T3 and extra edges)
      for (int i = 0; i < 6; i++) run8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br);

      // T4: second start mid-pass is ignored
      start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
      tick();                      // cycle N+1
      start8 = 1'b0;
      ndone = 0; done_at = 0; d_at = 8'h00;
      for (int c = 1; c <= 30; c++) begin
         if (c == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
         else start8 = 1'b0;
         if (done8 === 1'b1) begin
            ndone++;
            if (done_at == 0) begin done_at = c; d_at = diff8; end
         end
         tick();
      end
      start8 = 1'b0;
      check("t4_ndone", ndone, 1);
      check("t4_done_at", done_at, 9);
      check("t4_diff", 32'(d_at), 32'h23);
      last_diff = 8'h23;

      // T5: reset in the middle of SUB
      start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
      tick();                      // N+1
      start8 = 1'b0;
      tick(); tick(); tick();      // N+4
      rst = 1'b1;
      tick();
      check("t5_busy", 32'(busy8), 32'd0);
      check("t5_done", 32'(done8), 32'd0);
      check("t5_diff", 32'(diff8), 32'd0);
      check("t5_borrow", 32'(borrow8), 32'd0);
      // reset together with start: reset wins
      start8 = 1'b1;
      tick();
      check("rst_start_busy", 32'(busy8), 32'd0);
      rst = 1'b0; start8 = 1'b0;
      tick();
      check("rst_start_idle", 32'(busy8), 32'd0);
      last_diff = 8'h00;
      run8(8'h35, 8'h12, 8'h23, 1'b0);

      // T6: W=1 instance, all operand pairs
      run1(1'b0, 1'b1);
      run1(1'b1, 1'b0);
      run1(1'b1, 1'b1);
      run1(1'b0, 1'b0);

      // random operands against arithmetic expectations
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(0, 3) == 0 ? int'(ra) : int'($urandom));
         run8(ra, rb, 8'((int'(ra) - int'(rb)) & 255), (ra < rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
